// File: rtl/neuron_block_seq.sv
// Time-multiplexed single-neuron integrator: LANES axons per beat, then leak/threshold/reset.
// Define NEURON_SATURATE_EN to clamp the written potential instead of wrapping it.
module neuron_block_seq #(
    parameter int NUM_AXONS       = 256,
    parameter int LANES           = 16,
    parameter int NUM_WEIGHTS     = 4,
    parameter int WEIGHT_WIDTH    = 2,
    parameter int LEAK_WIDTH      = 9,
    parameter int THRESHOLD_WIDTH = 9,
    parameter int POTENTIAL_WIDTH = 9,
    parameter int NUM_RESET_MODES = 2,
    localparam int TYPE_W = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1,
    localparam int RM_W   = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    input  logic [LEAK_WIDTH-1:0]                leak_i,
    input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]  weights_i,
    input  logic [THRESHOLD_WIDTH-1:0]           positive_threshold_i,
    input  logic [THRESHOLD_WIDTH-1:0]           negative_threshold_i,
    input  logic [POTENTIAL_WIDTH-1:0]           reset_potential_i,
    input  logic [POTENTIAL_WIDTH-1:0]           current_potential_i,
    input  logic [RM_W-1:0]                      reset_mode_i,
    input  logic [NUM_AXONS-1:0]                 synapses_in_i,
    input  logic [NUM_AXONS-1:0]                 axon_in_i,
    input  logic [NUM_AXONS*TYPE_W-1:0]          axon_type_i,
    output logic [POTENTIAL_WIDTH-1:0]           write_potential_o,
    output logic                                 spike_o
);

    // state   | meaning
    // S_IDLE  | waiting for start_i; operands captured on acceptance
    // S_ACCUM | one beat per cycle, LANES axons added into r_acc
    // S_FIRE  | leak, threshold compare, reset select; outputs registered

    localparam int BEATS     = NUM_AXONS / LANES;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AX_W      = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
    localparam int ACC_WIDTH = WEIGHT_WIDTH + $clog2(NUM_AXONS) + 1;
    localparam int MAX_A     = (ACC_WIDTH > POTENTIAL_WIDTH) ? ACC_WIDTH : POTENTIAL_WIDTH;
    localparam int MAX_B     = (MAX_A > LEAK_WIDTH) ? MAX_A : LEAK_WIDTH;
    localparam int MAX_C     = (MAX_B > THRESHOLD_WIDTH) ? MAX_B : THRESHOLD_WIDTH;
    localparam int SUM_WIDTH = MAX_C + 2;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FIRE  = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [BEAT_W-1:0]                   r_beat;
    logic signed [ACC_WIDTH-1:0]         r_acc;
    logic signed [LEAK_WIDTH-1:0]        r_leak;
    logic signed [THRESHOLD_WIDTH-1:0]   r_pth;
    logic signed [THRESHOLD_WIDTH-1:0]   r_nth;
    logic signed [POTENTIAL_WIDTH-1:0]   r_rpot;
    logic signed [POTENTIAL_WIDTH-1:0]   r_cur;
    logic [RM_W-1:0]                     r_mode;
    logic [POTENTIAL_WIDTH-1:0]          r_wpot;
    logic                                r_spike;
    logic                                r_done;
    logic                                r_busy;

    logic                                w_accept;
    logic [NUM_AXONS-1:0]                w_hit;
    logic [TYPE_W-1:0]                   w_types [NUM_AXONS];
    logic signed [WEIGHT_WIDTH-1:0]      w_wtab [NUM_WEIGHTS];
    logic signed [ACC_WIDTH-1:0]         w_lane_sum;
    logic signed [SUM_WIDTH-1:0]         w_sum;
    logic signed [SUM_WIDTH-1:0]         w_pth;
    logic signed [SUM_WIDTH-1:0]         w_nth;
    logic signed [SUM_WIDTH-1:0]         w_res;
    logic                                w_pos;
    logic                                w_neg;
    logic [POTENTIAL_WIDTH-1:0]          w_wr;

    for (genvar a = 0; a < NUM_AXONS; a++) begin : g_types
        assign w_types[a] = axon_type_i[a*TYPE_W +: TYPE_W];
    end

    for (genvar k = 0; k < NUM_WEIGHTS; k++) begin : g_wtab
        assign w_wtab[k] = weights_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    assign w_hit    = synapses_in_i & axon_in_i;
    assign w_accept = (r_state == S_IDLE) && start_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_ACCUM;
            S_ACCUM: if (r_beat == BEAT_LAST) w_state_nxt = S_FIRE;
            S_FIRE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        logic [AX_W-1:0] idx;
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = AX_W'(int'(r_beat) * LANES + l);
            if (w_hit[idx]) begin
                w_lane_sum = w_lane_sum + ACC_WIDTH'(w_wtab[w_types[idx]]);
            end
        end
    end

    // Both threshold tests happen at full sum width so no compare can alias.
    always_comb begin
        w_sum = SUM_WIDTH'(r_cur) + SUM_WIDTH'(r_leak) + SUM_WIDTH'(r_acc);
        w_pth = SUM_WIDTH'(r_pth);
        w_nth = SUM_WIDTH'(r_nth);
        w_pos = (w_sum > w_pth);
        w_neg = (w_sum < w_nth);
        w_res = w_sum;
        if (w_pos) begin
            if (r_mode == RM_W'(1)) w_res = w_sum - w_pth;
            else                    w_res = SUM_WIDTH'(r_rpot);
        end else if (w_neg) begin
            w_res = SUM_WIDTH'(r_rpot);
        end
    end

`ifdef NEURON_SATURATE_EN
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((2 ** (POTENTIAL_WIDTH - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        if (w_res > SAT_MAX)      w_wr = POTENTIAL_WIDTH'(SAT_MAX);
        else if (w_res < SAT_MIN) w_wr = POTENTIAL_WIDTH'(SAT_MIN);
        else                      w_wr = POTENTIAL_WIDTH'(w_res);
    end
`else
    assign w_wr = POTENTIAL_WIDTH'(w_res);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_acc   <= '0;
            r_leak  <= '0;
            r_pth   <= '0;
            r_nth   <= '0;
            r_rpot  <= '0;
            r_cur   <= '0;
            r_mode  <= '0;
            r_wpot  <= '0;
            r_spike <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (r_state != S_IDLE);
            r_done  <= (r_state == S_FIRE);
            if (w_accept) begin
                r_beat <= '0;
                r_acc  <= '0;
                r_leak <= leak_i;
                r_pth  <= positive_threshold_i;
                r_nth  <= negative_threshold_i;
                r_rpot <= reset_potential_i;
                r_cur  <= current_potential_i;
                r_mode <= reset_mode_i;
            end else if (r_state == S_ACCUM) begin
                r_beat <= r_beat + BEAT_W'(1);
                r_acc  <= r_acc + w_lane_sum;
            end
            if (r_state == S_FIRE) begin
                r_wpot  <= w_wr;
                r_spike <= w_pos;
            end
        end
    end

    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign write_potential_o = r_wpot;
    assign spike_o           = r_spike;

endmodule

// File: tb/tb_neuron_block_seq.sv
// Scoreboard bench for neuron_block_seq at default parameters; honours NEURON_SATURATE_EN.
module tb_neuron_block_seq;
    localparam int NA = 256;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic         busy_o;
    logic         done_o;
    logic [8:0]   leak_i;
    logic [7:0]   weights_i;
    logic [8:0]   positive_threshold_i;
    logic [8:0]   negative_threshold_i;
    logic [8:0]   reset_potential_i;
    logic [8:0]   current_potential_i;
    logic [0:0]   reset_mode_i;
    logic [255:0] synapses_in_i;
    logic [255:0] axon_in_i;
    logic [511:0] axon_type_i;
    logic [8:0]   write_potential_o;
    logic         spike_o;

    neuron_block_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .leak_i(leak_i), .weights_i(weights_i),
        .positive_threshold_i(positive_threshold_i), .negative_threshold_i(negative_threshold_i),
        .reset_potential_i(reset_potential_i), .current_potential_i(current_potential_i),
        .reset_mode_i(reset_mode_i), .synapses_in_i(synapses_in_i), .axon_in_i(axon_in_i),
        .axon_type_i(axon_type_i), .write_potential_o(write_potential_o), .spike_o(spike_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int pot; int spk; } exp_t;
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   syn[NA];
    bit   axn[NA];
    int   ty[NA];
    int   wtab[4];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_axons();
        for (int a = 0; a < NA; a++) begin
            syn[a] = 1'b0; axn[a] = 1'b0; ty[a] = 0;
        end
        for (int k = 0; k < 4; k++) wtab[k] = 0;
    endtask

    task automatic pack();
        int t, w;
        for (int a = 0; a < NA; a++) begin
            t = ty[a];
            synapses_in_i[a] = syn[a];
            axon_in_i[a]     = axn[a];
            axon_type_i[a*2 +: 2] = t[1:0];
        end
        for (int k = 0; k < 4; k++) begin
            w = wtab[k];
            weights_i[k*2 +: 2] = w[1:0];
        end
    endtask

    function automatic void model(input int cur, input int leak, input int pth, input int nth,
                                  input int rpot, input int mode, output int pot, output int spk);
        int acc, s, r;
        acc = 0;
        for (int a = 0; a < NA; a++) if (syn[a] && axn[a]) acc += wtab[ty[a]];
        s   = cur + leak + acc;
        spk = 0;
        if (s > pth) begin
            spk = 1;
            r = (mode == 1) ? s - pth : rpot;
        end else if (s < nth) begin
            r = rpot;
        end else begin
            r = s;
        end
`ifdef NEURON_SATURATE_EN
        if (r > 255)  r = 255;
        if (r < -256) r = -256;
`else
        r = ((r % 512) + 512) % 512;
        if (r > 255) r -= 512;
`endif
        pot = r;
    endfunction

    task automatic run_case(input string tag, input int cur, input int leak, input int pth,
                            input int nth, input int rpot, input int mode, input int second_at);
        int   pot, spk, lat, extra;
        bit   seen, busy_ok;
        exp_t e;
        model(cur, leak, pth, nth, rpot, mode, pot, spk);
        e.pot = pot; e.spk = spk;
        sb.push_back(e);
        pack();
        current_potential_i  = cur[8:0];
        leak_i               = leak[8:0];
        positive_threshold_i = pth[8:0];
        negative_threshold_i = nth[8:0];
        reset_potential_i    = rpot[8:0];
        reset_mode_i         = mode[0:0];
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk({tag, "_busy_e0"}, busy_o, 0);
        lat = 0; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && lat < 40) begin
            @(negedge clk_i);
            lat++;
            start_i = (lat == second_at - 1);
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            if (done_o === 1'b1) seen = 1'b1;
        end
        start_i = 1'b0;
        chk({tag, "_latency"}, lat, 17);
        chk({tag, "_busy"}, busy_ok, 1);
        if (sb.size() > 0) e = sb.pop_front();
        if (seen) begin
            chk({tag, "_pot"}, $signed(write_potential_o), e.pot);
            chk({tag, "_spike"}, spike_o, e.spk);
        end
        @(negedge clk_i);
        chk({tag, "_done_pulse"}, done_o, 0);
        chk({tag, "_spike_hold"}, spike_o, e.spk);
        if (second_at > 0) begin
            extra = 0;
            repeat (25) begin
                @(negedge clk_i);
                if (done_o === 1'b1) extra++;
            end
            chk({tag, "_extra_done"}, extra, 0);
        end
    endtask

    initial begin
        int dones;
        rst_i = 1'b1; start_i = 1'b0;
        clear_axons(); pack();
        leak_i = '0; positive_threshold_i = '0; negative_threshold_i = '0;
        reset_potential_i = '0; current_potential_i = '0; reset_mode_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_spike", spike_o, 0);
        chk("rst_pot", write_potential_o, 0);
        rst_i = 1'b0;

        clear_axons();
        syn[0] = 1; axn[0] = 1; ty[0] = 0;
        syn[255] = 1; axn[255] = 1; ty[255] = 3;
        wtab[0] = 1; wtab[3] = -2;
        run_case("basic", 10, -1, 100, -100, 0, 0, -1);

        clear_axons();
        for (int a = 0; a < 8; a++) begin syn[a] = 1; axn[a] = 1; end
        syn[8] = 1; axn[9] = 1;
        wtab[0] = 1;
        run_case("abs_reset", 100, 0, 105, -100, 0, 0, -1);
        run_case("lin_reset", 100, 0, 105, -100, 0, 1, -1);
        run_case("eq_pth", 100, 0, 108, -100, 0, 1, -1);

        clear_axons();
        for (int a = 0; a < 16; a++) begin syn[a] = 1; axn[a] = 1; ty[a] = 1; end
        wtab[1] = -2;
        run_case("neg_reset", -100, 0, 100, -120, 5, 1, -1);
        run_case("eq_nth", -100, 0, 100, -132, 5, 0, -1);

        clear_axons();
        for (int a = 0; a < NA; a++) begin syn[a] = 1; axn[a] = 1; end
        wtab[0] = 1;
        run_case("saturate", 200, 0, 50, -100, 0, 1, -1);

        clear_axons();
        syn[0] = 1; axn[0] = 1; syn[255] = 1; axn[255] = 1; ty[255] = 3;
        wtab[0] = 1; wtab[3] = -2;
        pack();
        current_potential_i = 9'd10; leak_i = 9'h1FF;
        positive_threshold_i = 9'd100; negative_threshold_i = 9'h19C;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_spike", spike_o, 0);
        chk("midrst_pot", write_potential_o, 0);
        dones = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_pot_idle", write_potential_o, 0);

        run_case("busy_start", 10, -1, 100, -100, 0, 0, 3);

        for (int i = 0; i < 6; i++) begin
            clear_axons();
            for (int a = 0; a < NA; a++) begin
                syn[a] = $urandom_range(0, 1) == 1;
                axn[a] = $urandom_range(0, 1) == 1;
                ty[a]  = $urandom_range(0, 3);
            end
            for (int k = 0; k < 4; k++) wtab[k] = int'($urandom_range(0, 3)) - 2;
            run_case($sformatf("rand%0d", i),
                     int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                     int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                     int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 1)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
